// File: rtl/div_pkg.sv
// Shared constants and types for the divide/rsqrt operand front/back end.
// Optional feature macro used by the block: DIV_NORM_DP_EN (two-beat double precision).
package div_pkg;

  // Result returned for a zero operand, whatever its sign.
  localparam logic [31:0] ZERO_RES = 32'h7FFF_FFFF;

  // Divide ROM geometry; the top address bit selects the rsqrt half.
  localparam int ROM_AW  = 10;
  localparam int ROM_DW  = 16;
  localparam int RSQ_BIT = 9;

  // Acceptance edge to res_vld, in cycles. Informational only.
  localparam int LAT = 2;

  // Per-op state carried alongside the ROM access.
  typedef struct packed {
    logic       neg;
    logic       zero;
    logic       rsq;
    logic [4:0] lz;
  } stage_b_t;

endpackage

// File: rtl/div_norm_seq_if.sv
// Operand/result bus of div_norm_seq.
// Handshake: there is no ready. A beat is accepted on every clk edge where
// in_vld is high. res_vld is a one-cycle pulse per low beat, and res_data
// holds its value between pulses. dp_pend reports that a high half is held.
interface div_norm_seq_if;
  import div_pkg::*;

  logic              in_vld;
  logic              in_hi;
  logic              in_rsq;
  logic [15:0]       in_data;
  logic              res_vld;
  logic [31:0]       res_data;
  logic              dp_pend;

  modport master (
    output in_vld, in_hi, in_rsq, in_data,
    input  res_vld, res_data, dp_pend
  );

  modport slave (
    input  in_vld, in_hi, in_rsq, in_data,
    output res_vld, res_data, dp_pend
  );

endinterface

// File: rtl/div_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
// For an all-zero input the count reads 0 and zero is set.
module div_lzc32 (
  input  logic [31:0] x,
  output logic [4:0]  cnt,
  output logic        zero
);

  // Scan upward so the highest set bit writes the count last.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) cnt = 5'(31 - i);
    end
  end

  assign zero = (x == '0);

endmodule

// File: rtl/div_norm_seq.sv
// Operand front/back end for the reciprocal / reciprocal-square-root unit.
// Stage A holds the assembled operand and drives the ROM address
// combinationally; stage B travels beside the ROM read; the output register
// denormalises and sign-restores the ROM mantissa.
// Optional feature macro: DIV_NORM_DP_EN enables two-beat 32-bit operands.
module div_norm_seq
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                reset_l,
  div_norm_seq_if.slave       bus,
  output logic [ROM_AW-1:0]   rom_a,
  input  logic [ROM_DW-1:0]   rom_out
);

  logic        lo_beat;
  logic [31:0] op_next;

`ifdef DIV_NORM_DP_EN
  logic [15:0] hi_reg;
  logic        dp_pend_q;

  // Hold the upper half until its low beat arrives; a new hi beat overwrites.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      hi_reg    <= '0;
      dp_pend_q <= 1'b0;
    end else if (bus.in_vld) begin
      if (bus.in_hi) begin
        hi_reg    <= bus.in_data;
        dp_pend_q <= 1'b1;
      end else begin
        dp_pend_q <= 1'b0;
      end
    end
  end

  assign lo_beat     = bus.in_vld && !bus.in_hi;
  assign op_next     = dp_pend_q ? {hi_reg, bus.in_data}
                                 : {{16{bus.in_data[15]}}, bus.in_data};
  assign bus.dp_pend = dp_pend_q;
`else
  // Single precision only: every beat is a low beat.
  logic unused_hi;
  assign unused_hi   = bus.in_hi;
  assign lo_beat     = bus.in_vld;
  assign op_next     = {{16{bus.in_data[15]}}, bus.in_data};
  assign bus.dp_pend = 1'b0;
`endif

  // Stage A registers
  logic        a_vld;
  logic [31:0] a_op;
  logic        a_rsq;

  // Capture the assembled operand on its acceptance edge.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      a_vld <= 1'b0;
      a_op  <= '0;
      a_rsq <= 1'b0;
    end else begin
      a_vld <= lo_beat;
      if (lo_beat) begin
        a_op  <= op_next;
        a_rsq <= bus.in_rsq;
      end
    end
  end

  // Stage A datapath: magnitude, leading-zero count, normalisation.
  logic        a_neg;
  logic [31:0] a_x;
  logic [4:0]  a_lz;
  logic        a_zero;
  logic [31:0] a_nrm;

  // 0x8000_0000 negates to itself, which is the wanted unsigned magnitude.
  assign a_neg = a_op[31];
  assign a_x   = a_neg ? (~a_op + 32'd1) : a_op;

  div_lzc32 u_lzc (
    .x    (a_x),
    .cnt  (a_lz),
    .zero (a_zero)
  );

  assign a_nrm = a_x << a_lz;

  logic unused_nrm;
  assign unused_nrm = ^{a_nrm[31], a_nrm[21:0]};

  logic [ROM_AW-1:0] rom_a_c;

  // ROM address: rsqrt keeps the exponent parity in bit 0. Zero operands
  // present address 0, which also makes rom_a read 0 out of reset.
  always_comb begin
    rom_a_c = '0;
    if (!a_zero) begin
      if (a_rsq) begin
        rom_a_c[RSQ_BIT]     = 1'b1;
        rom_a_c[RSQ_BIT-1:0] = {a_nrm[30:23], a_lz[0]};
      end else begin
        rom_a_c[RSQ_BIT-1:0] = a_nrm[30:22];
      end
    end
  end

  assign rom_a = rom_a_c;

  // Stage B registers, aligned with the ROM's own address register
  logic     b_vld;
  stage_b_t b;

  // Move op state alongside the ROM access.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      b_vld <= 1'b0;
      b     <= '0;
    end else begin
      b_vld <= a_vld;
      if (a_vld) begin
        b.neg  <= a_neg;
        b.zero <= a_zero;
        b.rsq  <= a_rsq;
        b.lz   <= a_lz;
      end
    end
  end

  // Denormalise: rsqrt halves the exponent shift.
  logic [31:0] mant;
  logic [4:0]  sh;
  logic [31:0] mag;
  logic [31:0] res;

  assign mant = {2'b01, rom_out, 14'b0};
  assign sh   = b.rsq ? ((5'd31 - b.lz) >> 1) : (5'd31 - b.lz);
  assign mag  = mant >> sh;
  assign res  = b.zero ? ZERO_RES : (b.neg ? ~mag : mag);

  // Output register: one pulse per op, data held between pulses.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      bus.res_vld  <= 1'b0;
      bus.res_data <= '0;
    end else begin
      bus.res_vld <= b_vld;
      if (b_vld) bus.res_data <= res;
    end
  end

endmodule

// File: tb/tb_div_norm_seq.sv
// Self-checking bench for div_norm_seq with a registered behavioural ROM.
// Expected results come from an arithmetic reference model and go into a
// scoreboard; a negedge monitor pops and compares on every res_vld.
module tb_div_norm_seq;

`ifdef DIV_NORM_DP_EN
  localparam bit DP = 1'b1;
`else
  localparam bit DP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [9:0]  rom_a;
  logic [15:0] rom_out;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_norm_seq_if bus ();

  div_norm_seq dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus),
    .rom_a   (rom_a),
    .rom_out (rom_out)
  );

  // Behavioural divide ROM: registers its address on clk.
  logic [15:0] rom_mem [1024];
  always @(posedge clk) rom_out <= rom_mem[rom_a];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [9:0]  exp_a_q[$];
  bit          a_chk_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          dp_m = 1'b0;
  logic [15:0] hi_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result from sign/magnitude arithmetic and powers of two.
  function automatic void model(input logic [31:0] op, input bit rsq,
                                output logic [9:0] addr, output bit addr_chk,
                                output logic [31:0] res);
    longint v, x, n, mant, mag;
    int     msb, lz, sh;
    v = longint'($signed(op));
    x = (v < 0) ? -v : v;
    if (x == 0) begin
      addr     = '0;
      addr_chk = 1'b0;
      res      = 32'h7FFF_FFFF;
      return;
    end
    msb = 0;
    while ((longint'(1) << (msb + 1)) <= x) msb++;
    lz = 31 - msb;
    n  = (x << lz) & 64'hFFFF_FFFF;
    if (rsq) addr = 10'(512 + ((n >> 23) % 256) * 2 + (lz % 2));
    else     addr = 10'((n >> 22) % 512);
    addr_chk = 1'b1;
    mant = (longint'(1) << 30) + longint'(rom_mem[addr]) * 16384;
    sh   = rsq ? (31 - lz) / 2 : (31 - lz);
    mag  = mant >> sh;
    res  = (v < 0) ? ~32'(mag) : 32'(mag);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic beat(input bit hi, input bit rsq, input logic [15:0] d,
                      input bit use_lit, input logic [31:0] lit_res, input logic [9:0] lit_a);
    logic [31:0] op, r;
    logic [9:0]  a;
    bit          ac;
    bus.in_vld  = 1'b1;
    bus.in_hi   = hi;
    bus.in_rsq  = rsq;
    bus.in_data = d;
    if (DP && hi) begin
      hi_m = d;
      dp_m = 1'b1;
    end else begin
      op   = (DP && dp_m) ? {hi_m, d} : {{16{d[15]}}, d};
      dp_m = 1'b0;
      model(op, rsq, a, ac, r);
      if (use_lit) begin
        r = lit_res;
        a = lit_a;
      end
      exp_q.push_back(r);
      exp_cyc_q.push_back(cyc + 3);
      exp_a_q.push_back(a);
      a_chk_q.push_back(ac);
    end
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    bus.in_vld = 1'b0;
    reset_l    = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_a_q.delete();
    a_chk_q.delete();
    dp_m = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_res_vld", 32'(bus.res_vld), 32'd0);
    chk("post_reset_res_data", bus.res_data, 32'd0);
    chk("post_reset_dp_pend", 32'(bus.dp_pend), 32'd0);
  endtask

  // ---------------- monitor ----------------
  bit          lo_d1 = 1'b0;
  bit          rst_seen = 1'b0;
  logic [31:0] last_res = '0;

  always @(posedge clk) begin
    lo_d1    <= reset_l && bus.in_vld && !(DP && bus.in_hi);
    rst_seen <= !reset_l;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    int          ec;
    logic [9:0]  ea;
    bit          ac;
    if (rst_seen) begin
      chk("reset_res_vld", 32'(bus.res_vld), 32'd0);
      chk("reset_res_data", bus.res_data, 32'd0);
      chk("reset_dp_pend", 32'(bus.dp_pend), 32'd0);
      chk("reset_rom_a", 32'(rom_a), 32'd0);
      last_res = '0;
    end else begin
      if (bus.res_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_vld", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("res_data", bus.res_data, e);
          chk("res_latency", 32'(cyc), 32'(ec));
          last_res = e;
        end
      end else begin
        chk("res_hold", bus.res_data, last_res);
      end
      if (lo_d1) begin
        if (exp_a_q.size() == 0) begin
          chk("rom_a_underflow", 32'd1, 32'd0);
        end else begin
          ea = exp_a_q.pop_front();
          ac = a_chk_q.pop_front();
          if (ac) chk("rom_a", 32'(rom_a), 32'(ea));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] d;
    int          sel;
    bus.in_vld  = 1'b0;
    bus.in_hi   = 1'b0;
    bus.in_rsq  = 1'b0;
    bus.in_data = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
    rom_mem[10'h000] = 16'hFFFF;
    rom_mem[10'h201] = 16'h8000;

    idle(3);
    reset_l = 1'b1;
    idle(2);

    // Single-precision reciprocal, zero, rsqrt
    beat(0, 0, 16'h0001, 1, 32'h7FFF_C000, 10'h000);
    idle(3);
    beat(0, 0, 16'h0002, 1, 32'h3FFF_E000, 10'h000);
    beat(0, 0, 16'hFFFF, 1, 32'h8000_3FFF, 10'h000);
    beat(0, 0, 16'h0000, 1, 32'h7FFF_FFFF, 10'h000);
    beat(0, 1, 16'h0004, 1, 32'h3000_0000, 10'h201);
    idle(4);

    // Double precision: hi 0x0001, lo 0x0000
    beat(1, 0, 16'h0001, 0, '0, '0);
    chk("dp_pend_after_hi", 32'(bus.dp_pend), 32'(dp_m));
`ifdef DIV_NORM_DP_EN
    beat(0, 0, 16'h0000, 1, 32'h0000_7FFF, 10'h000);
`else
    beat(0, 0, 16'h0000, 0, '0, '0);
`endif
    chk("dp_pend_after_lo", 32'(bus.dp_pend), 32'd0);
    idle(4);

    // Reset with two low beats in flight
    beat(0, 0, 16'h0003, 0, '0, '0);
    beat(0, 1, 16'h1234, 0, '0, '0);
    do_reset();
    idle(3);

    // Hi beat then reset: next low beat is sign-extended
    beat(1, 0, 16'h1234, 0, '0, '0);
    do_reset();
    beat(0, 0, 16'hFFFF, 1, 32'h8000_3FFF, 10'h000);
    idle(4);

    // Throughput: eight back-to-back low beats
    for (int i = 0; i < 8; i++) beat(0, 1'($urandom_range(0, 1)), 16'($urandom), 0, '0, '0);
    idle(4);

    // Randomised mix with boundary operands and hi beats
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      d = 16'h0000;
      else if (sel == 1) d = 16'h8000;
      else if (sel == 2) d = 16'hFFFF;
      else               d = 16'($urandom);
      beat(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), d, 0, '0, '0);
      chk("dp_pend", 32'(bus.dp_pend), 32'(dp_m));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div_norm_seq.md
Name: div_norm_seq

Overview:
- Operand front/back end for the VU reciprocal and reciprocal-square-root unit.
- Accepts a signed 16-bit (single) or 32-bit (double, two-beat) operand, then takes its absolute value and normalises it with a leading-zero count.
- Drives the 10-bit address of the downstream standard-cell divide ROM, which registers its address on clk and returns the interpolated 16-bit mantissa.
- Denormalises and sign-restores that mantissa into a 32-bit result. Fully pipelined, no back-pressure.

Parameters:
- ZERO_RES, 32'h7FFF_FFFF, result for a zero operand (sign ignored).
- LAT, 2, fixed latency in cycles from input acceptance edge to res_vld; documentation only, not an override.

Ports:
- clk  in  1  clock.
- reset_l  in  1  synchronous active-low reset.
- in_vld  in  1  operand beat valid; accepted every cycle it is high.
- in_hi  in  1  beat is upper half of a double-precision operand.
- in_rsq  in  1  1 = reciprocal square root, 0 = reciprocal (low/single beat only).
- in_data  in  16  operand half-word.
- rom_a  out  10  divide ROM address.
- rom_out  in  16  ROM result, valid one cycle after rom_a is sampled.
- res_vld  out  1  result valid pulse.
- res_data  out  32  result.
- dp_pend  out  1  high half held, waiting for low beat.

Behaviour:
- Reset (reset_l low at clk edge):
  - Stage valids, dp_pend, hi register, res_vld and res_data all go to 0.
  - rom_a reads 0.
  - Any in-flight op is discarded, with no res_vld afterwards.
- Beat with in_vld=1, in_hi=1:
  - in_data is stored in hi_reg and dp_pend is set. No result is produced.
  - A second hi beat overwrites hi_reg.
- Beat with in_vld=1, in_hi=0 (stage A load):
  - operand = dp_pend ? {hi_reg, in_data} : sign-extend(in_data). dp_pend is cleared in the same edge.
- Stage A (registered operand):
  - neg = operand[31].
  - x = neg ? -operand : operand, unsigned 32-bit; 0x8000_0000 stays 0x8000_0000.
  - lz = leading zeros of x (0..31); nrm = x << lz.
  - rom_a = in_rsq ? {1'b1, nrm[30:23], lz[0]} : {1'b0, nrm[30:22]}.
  - rom_a is combinational from stage A registers.
  - When x == 0: rom_a is don't-care and a zero flag travels down the pipe.
- Stage B (latched on the same edge the ROM samples rom_a): holds neg, zero, rsq and lz.
- Result computation:
  - mant = {2'b01, rom_out, 14'b0}.
  - sh = rsq ? (31-lz)>>1 : 31-lz.
  - mag = mant >> sh.
  - res = zero ? ZERO_RES : (neg ? ~mag : mag), i.e. one's-complement negate.
  - res is registered into res_data with res_vld=1 on the next edge.
- Latency and throughput:
  - Acceptance edge E0, ROM sample E1, res_vld high after E2; res_vld lasts exactly one cycle per low beat.
  - Back-to-back low beats give back-to-back results.
  - res_data holds its last value when res_vld=0.
- Simultaneous events: a hi beat may arrive while a low op is in stage A or B; in-flight ops are unaffected.

Optional Feature:
- DIV_NORM_DP_EN defined: double-precision two-beat support as above.
- DIV_NORM_DP_EN undefined: in_hi is ignored (treated as 0), hi_reg is removed, dp_pend is tied 0, and every low beat is sign-extended. A beat with in_hi=1 is then processed as a single-precision op.

Decomposition:
- Shared package div_pkg: ZERO_RES, ROM address width 10, ROM data width 16, rsq select bit position 9.
- One sub-module, div_lzc32: combinational 32-bit leading-zero counter, 5-bit count plus all-zero flag.
- Bench pairs the block with a behavioural ROM model registered on clk.

Test Plan:
- Reset:
  - Drive reset_l=0 mid-stream with two low beats in flight -> res_vld stays 0, res_data=0 and dp_pend=0 on the cycle after release.
- Single-precision reciprocal:
  - in_data=0x0001, rsq=0, ROM model returns 0xFFFF for address 0x000 -> rom_a=0x000 one cycle later; res_data=0x7FFF_C000 with res_vld exactly 2 cycles after acceptance.
  - in_data=0x0002 -> rom_a=0x000, res_data=0x3FFF_E000.
  - in_data=0xFFFF (-1) -> res_data=0x8000_3FFF.
- Zero operand:
  - in_data=0x0000 -> res_data=0x7FFF_FFFF regardless of rom_out.
- Double precision:
  - Hi beat 0x0001 then low beat 0x0000 (x=0x0001_0000, lz=15) with ROM returning 0xFFFF -> dp_pend high between beats; rom_a=0x000; res_data=0x0000_7FFF.
  - Hi beat followed by reset -> dp_pend=0 and the next low beat is sign-extended.
- Reciprocal square root:
  - in_data=0x0004, rsq=1 -> lz=29, rom_a={1, 0x00, 1}=0x201, sh=1; with ROM returning 0x8000, res_data=0x3000_0000.
- Throughput:
  - Eight consecutive low beats -> eight consecutive res_vld cycles, in order, matching the scoreboard.
